// File: rtl/seqdet_pkg.sv
// Shared types and limits for the serial pattern detector.
package seqdet_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } seqdet_state_t;

  localparam int unsigned SEQDET_MAX_WIDTH = 16;

endpackage

// File: rtl/seqdet_hist.sv
// Serial history shift register with a fill counter that saturates at WIDTH.
// Exposes the post-shift history and the post-increment fullness so that
// the match can be evaluated on the same edge that samples the bit.
module seqdet_hist
  import seqdet_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_din,
  input  logic             i_fill_clr,
  output logic [WIDTH-1:0] o_hist_nxt,
  output logic             o_full_nxt,
  output logic             o_full
);

  localparam int unsigned      FW       = $clog2(WIDTH + 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(WIDTH);

  logic [WIDTH-1:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic [FW-1:0]    w_fill_inc;

  assign o_hist_nxt = {r_hist[WIDTH-2:0], i_din};
  assign w_fill_inc = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + FW'(1);
  assign o_full_nxt = (w_fill_inc == FILL_MAX);
  assign o_full     = (r_fill == FILL_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_en) begin
      r_hist <= o_hist_nxt;
      r_fill <= i_fill_clr ? '0 : w_fill_inc;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector with runtime-loadable pattern and overlap control.
// Optional saturating match counter enabled by SEQDET_COUNT_EN.
module seq_detector
  import seqdet_pkg::*;
#(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [WIDTH-1:0]  PATTERN = 4'b1011,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [WIDTH-1:0] pat_in,
  output logic             y,
  output logic             armed
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  if (WIDTH < 2 || WIDTH > SEQDET_MAX_WIDTH) begin : g_bad_width
    $error("seq_detector: WIDTH out of range");
  end

  logic [WIDTH-1:0] r_pat;
  seqdet_state_t    r_state;
  seqdet_state_t    w_state_nxt;
  logic             r_y;
  logic             w_match;
  logic             w_fill_clr;
  logic [WIDTH-1:0] w_hist_nxt;
  logic             w_full_nxt;
  logic             w_full;

  seqdet_hist #(
    .WIDTH (WIDTH)
  ) u_hist (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (pat_load),
    .i_en       (en),
    .i_din      (din),
    .i_fill_clr (w_fill_clr),
    .o_hist_nxt (w_hist_nxt),
    .o_full_nxt (w_full_nxt),
    .o_full     (w_full)
  );

  // A load on the same edge drops the sampled bit, so it can never match.
  assign w_match    = en && !pat_load && (w_hist_nxt == r_pat) && w_full_nxt;
  assign w_fill_clr = w_match && !overlap;

  always_comb begin
    w_state_nxt = w_full ? ARMED : FILL;
    if (pat_load) begin
      w_state_nxt = FILL;
    end else if (en) begin
      w_state_nxt = (w_full_nxt && !w_fill_clr) ? ARMED : FILL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FILL;
      r_y     <= 1'b0;
      r_pat   <= PATTERN;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_match;
      if (pat_load) begin
        r_pat <= pat_in;
      end
    end
  end

  assign y     = r_y;
  assign armed = (r_state == ARMED);

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_cnt;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector (WIDTH=4, PATTERN=1011, CNT_W=2).
module tb_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       din;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       y;
  logic       armed;
`ifdef SEQDET_COUNT_EN
  logic [1:0] match_cnt;
`endif

  seq_detector #(
    .WIDTH   (4),
    .PATTERN (4'b1011),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .din       (din),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .y         (y),
    .armed     (armed)
`ifdef SEQDET_COUNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       y;
    logic       armed;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_hist;
  logic [3:0] m_pat;
  int         m_fill;
  logic [1:0] m_cnt;

  task automatic model_reset();
    m_hist = 4'b0000;
    m_pat  = 4'b1011;
    m_fill = 0;
    m_cnt  = 2'b00;
    sb.delete();
  endtask

  // Drive one cycle, push the model's expectation, then compare after the edge.
  task automatic step(input logic i_en, input logic i_din, input logic i_ov,
                      input logic i_ld, input logic [3:0] i_pin, input string tag);
    exp_t e;
    logic m;
    en       = i_en;
    din      = i_din;
    overlap  = i_ov;
    pat_load = i_ld;
    pat_in   = i_pin;
    m = 1'b0;
    if (i_ld) begin
      m_pat  = i_pin;
      m_hist = 4'b0000;
      m_fill = 0;
    end else if (i_en) begin
      m_hist = {m_hist[2:0], i_din};
      if (m_fill < 4) m_fill++;
      m = (m_hist == m_pat) && (m_fill == 4);
      if (m && !i_ov) m_fill = 0;
      if (m && m_cnt != 2'b11) m_cnt = m_cnt + 2'b01;
    end
    e.y     = m;
    e.armed = (m_fill == 4);
    e.cnt   = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, "_y"}, 32'(y), 32'(e.y));
    check({tag, "_armed"}, 32'(armed), 32'(e.armed));
`ifdef SEQDET_COUNT_EN
    check({tag, "_cnt"}, 32'(match_cnt), 32'(e.cnt));
`endif
    if (y === 1'b1) pulses++;
  endtask

  task automatic bits(input logic [7:0] seq, input int n, input logic ov, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, seq[i], ov, 1'b0, 4'b0000, tag);
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset    = 1'b0;
    en       = 1'b0;
    din      = 1'b0;
    pat_load = 1'b0;
    model_reset();
    #1;
    check({tag, "_rst_y"}, 32'(y), 32'd0);
    check({tag, "_rst_armed"}, 32'(armed), 32'd0);
`ifdef SEQDET_COUNT_EN
    check({tag, "_rst_cnt"}, 32'(match_cnt), 32'd0);
`endif
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b0;
    din      = 1'b0;
    overlap  = 1'b1;
    pat_load = 1'b0;
    pat_in   = 4'b0000;
    model_reset();

    // Overlapping: 1011011 matches after bits 4 and 7.
    apply_reset("s1");
    bits(8'b0101_1011, 7, 1'b1, "s1");
    check("s1_pulses", 32'(pulses), 32'd2);

    // Non-overlapping: only the first match.
    apply_reset("s2");
    bits(8'b0101_1011, 7, 1'b0, "s2");
    check("s2_pulses", 32'(pulses), 32'd1);

    // Gaps with en=0 hold the history.
    apply_reset("s3");
    bits(8'b0000_0101, 3, 1'b1, "s3");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, "s3_idle");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, "s3_idle");
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, "s3_last");
    check("s3_pulses", 32'(pulses), 32'd1);

    // Asynchronous reset while y and armed are high, then refill from empty.
    apply_reset("s4");
    bits(8'b0000_1011, 4, 1'b1, "s4");
    check("s4_pre_y", 32'(y), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("s4_async_y", 32'(y), 32'd0);
    check("s4_async_armed", 32'(armed), 32'd0);
`ifdef SEQDET_COUNT_EN
    check("s4_async_cnt", 32'(match_cnt), 32'd0);
`endif
    model_reset();
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    bits(8'b0000_0001, 1, 1'b1, "s4_one");
    check("s4_one_pulses", 32'(pulses), 32'd0);
    bits(8'b0000_0011, 3, 1'b1, "s4_fill");
    check("s4_fill_pulses", 32'(pulses), 32'd1);

    // Pattern load drops the concurrent bit; old pattern no longer matches.
    apply_reset("s5");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, "s5_load");
    bits(8'b0000_0110, 4, 1'b1, "s5_new");
    check("s5_new_pulses", 32'(pulses), 32'd1);
    bits(8'b0000_1011, 4, 1'b1, "s5_old");
    check("s5_total_pulses", 32'(pulses), 32'd1);

    // Periodic pattern 1111 with overlap: continuous y, counter saturates.
    apply_reset("s6");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, "s6_load");
    bits(8'b1111_1111, 8, 1'b1, "s6");
    check("s6_pulses", 32'(pulses), 32'd5);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, "s6_reload");
`ifdef SEQDET_COUNT_EN
    check("s6_cnt_kept", 32'(match_cnt), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
